// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares the single memory data port between the CPU load/store path and the RAS spill/fill engine.
// Latency: grant, cpu_hold and mem_* are combinational in the request cycle; read data is tagged back RD_LAT cycles later.
// Backpressure: the CPU normally wins; define ARB_STARVE_GUARD_EN to add a starvation guard that stalls the CPU for one cycle.
module mem_port_arbiter #(
    parameter int AW         = 32,
    parameter int DW         = 32,
    parameter int RD_LAT     = 1,
    parameter int STARVE_MAX = 8
) (
    input  logic          clk,
    input  logic          rst,
    // CPU data path
    input  logic          cpu_rd,
    input  logic          cpu_wr,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_din,
    input  logic [3:0]    cpu_wen,
    input  logic [2:0]    cpu_strctrl,
    output logic          cpu_hold,
    output logic          cpu_rvalid,
    output logic [DW-1:0] cpu_dout,
    // RAS spill/fill engine
    input  logic          ras_rd,
    input  logic          ras_wr,
    input  logic [AW-1:0] ras_addr,
    input  logic [DW-1:0] ras_din,
    output logic          ras_gnt,
    output logic          ras_rvalid,
    output logic [DW-1:0] ras_dout,
    // memory port
    output logic          mem_en,
    output logic [3:0]    mem_wen,
    output logic [2:0]    mem_strctrl,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_din,
    input  logic [DW-1:0] mem_dout
);

    // Reject parameter values the tag pipe and counter cannot represent.
    if (RD_LAT < 1 || RD_LAT > 4) begin : g_bad_rd_lat
        $error("mem_port_arbiter: RD_LAT must be 1..4");
    end
    if (STARVE_MAX < 1 || STARVE_MAX > 255) begin : g_bad_starve_max
        $error("mem_port_arbiter: STARVE_MAX must be 1..255");
    end

    logic cpu_req;
    logic ras_req;
    logic cpu_sel;   // CPU owns the port this cycle
    logic ras_sel;   // RAS owns the port this cycle
    logic force_st;  // CPU is being stalled to let RAS through

    assign cpu_req = cpu_rd | cpu_wr;
    assign ras_req = ras_rd | ras_wr;

`ifdef ARB_STARVE_GUARD_EN
    localparam logic [7:0] STARVE_LIM = 8'(STARVE_MAX);

    typedef enum logic {
        NORMAL = 1'b0,
        FORCE  = 1'b1
    } state_t;

    state_t     state;
    state_t     state_nxt;
    logic [7:0] starve_cnt;
    logic [7:0] starve_nxt;

    // State and starvation counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= NORMAL;
            starve_cnt <= 8'd0;
        end else begin
            state      <= state_nxt;
            starve_cnt <= starve_nxt;
        end
    end

    // Winner selection and next state; FORCE is entered the cycle after the counter hits its limit.
    always_comb begin
        state_nxt  = NORMAL;
        starve_nxt = starve_cnt;
        cpu_sel    = 1'b0;
        ras_sel    = 1'b0;
        force_st   = 1'b0;
        case (state)
            NORMAL: begin
                if (cpu_req) begin
                    cpu_sel = 1'b1;
                end else if (ras_req) begin
                    ras_sel = 1'b1;
                end
                if (ras_sel) begin
                    starve_nxt = 8'd0;
                end else if (ras_req && starve_cnt != 8'hFF) begin
                    starve_nxt = starve_cnt + 8'd1;
                end
                if (ras_req && !ras_sel && starve_nxt >= STARVE_LIM) begin
                    state_nxt = FORCE;
                end
            end
            FORCE: begin
                // A withdrawn RAS request leaves the port idle; the CPU is still held.
                force_st   = 1'b1;
                ras_sel    = ras_req;
                starve_nxt = 8'd0;
                state_nxt  = NORMAL;
            end
            default: begin
                state_nxt  = NORMAL;
                starve_nxt = 8'd0;
            end
        endcase
    end
`else
    // Fixed CPU priority: RAS only gets cycles the CPU leaves free.
    always_comb begin
        cpu_sel  = cpu_req;
        ras_sel  = ras_req & ~cpu_req;
        force_st = 1'b0;
    end
`endif

    // Drive the memory port from the winner; everything reads as zero while in reset.
    always_comb begin
        mem_en      = 1'b0;
        mem_wen     = 4'b0000;
        mem_strctrl = 3'b000;
        mem_addr    = '0;
        mem_din     = '0;
        ras_gnt     = 1'b0;
        cpu_hold    = 1'b0;
        if (!rst) begin
            cpu_hold = force_st;
            if (cpu_sel) begin
                mem_en      = 1'b1;
                mem_addr    = cpu_addr;
                mem_din     = cpu_din;
                mem_strctrl = cpu_strctrl;
                mem_wen     = cpu_wr ? cpu_wen : 4'b0000;
            end else if (ras_sel) begin
                mem_en      = 1'b1;
                ras_gnt     = 1'b1;
                mem_addr    = ras_addr;
                mem_din     = ras_din;
                mem_strctrl = ras_wr ? 3'b100 : 3'b000;
                mem_wen     = ras_wr ? 4'b1111 : 4'b0000;
            end
        end
    end

    // Tag pipe: one {valid, owner} stage per cycle of read latency; owner 1 means RAS.
    logic              rd_issue;
    logic              rd_owner;
    logic [RD_LAT-1:0] tag_vld;
    logic [RD_LAT-1:0] tag_own;

    assign rd_issue = ~rst & ((cpu_sel & cpu_rd) | (ras_sel & ras_rd));
    assign rd_owner = ras_sel;

    // Shift read tags toward the output stage; reset drops anything in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            tag_vld <= '0;
            tag_own <= '0;
        end else begin
            tag_vld[0] <= rd_issue;
            tag_own[0] <= rd_owner;
            for (int i = 1; i < RD_LAT; i++) begin
                tag_vld[i] <= tag_vld[i-1];
                tag_own[i] <= tag_own[i-1];
            end
        end
    end

    assign cpu_rvalid = ~rst & tag_vld[RD_LAT-1] & ~tag_own[RD_LAT-1];
    assign ras_rvalid = ~rst & tag_vld[RD_LAT-1] &  tag_own[RD_LAT-1];
    assign cpu_dout   = rst ? '0 : mem_dout;
    assign ras_dout   = rst ? '0 : mem_dout;

endmodule
